// File: rtl/uarith_sequencer.sv
// rtl/uarith_sequencer.sv - multi-cycle sequencer for the unsigned arithmetic unit
//
// Runs one add, subtract, multiply or divide at a time over a start/ready handshake.
// Add and subtract take one execute cycle. Multiply (shift-add) and divide
// (restoring shift-subtract) take WIDTH iterations. Results are held until the
// next operation finishes.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     request, sampled only while ready=1
//   OpCode    00 add, 01 subtract, 10 multiply, 11 divide
//   A, B      operands (A = minuend/dividend, B = subtrahend/divisor)
//   ready     high only in IDLE
//   done      one-cycle pulse when results become valid
//   Answer    sum, difference, product low word or quotient
//   AnswerHi  product high word or remainder, 0 for add/sub
//   carry     add carry-out / subtract borrow, 0 for mul/div
//   div0      divide with B=0
module uarith_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       OpCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Answer,
  output logic [WIDTH-1:0] AnswerHi,
  output logic             carry,
  output logic             div0
);

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t state, state_next;

  // Operands and control captured at accept; later input changes are ignored.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             div0_pend;
  logic [WIDTH-1:0] cnt;

  // Multiply accumulator: {prod_hi, prod_lo}, multiplier bits consumed from prod_lo LSB.
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  // Divide: remainder plus dividend/quotient shift register.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic             last_iter;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;

  assign last_iter = (cnt == WIDTH'(WIDTH - 1));

  assign add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
  // Top bit of the extended difference is the borrow, i.e. A < B.
  assign sub_diff = {1'b0, a_reg} - {1'b0, b_reg};

  // One shift-add step: conditionally add B into the high half, then shift the
  // whole (2*WIDTH+1)-bit value right by one, keeping the add carry.
  assign mul_sum  = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_lo[WIDTH-1:1]};

  // One restoring step on the WIDTH+1 bit partial remainder. With B=0 the
  // subtract always succeeds, giving quotient all-ones and remainder A.
  assign div_shift    = {rem, quo[WIDTH-1]};
  assign div_ge       = (div_shift >= {1'b0, b_reg});
  assign div_rem_next = div_ge ? WIDTH'(div_shift - {1'b0, b_reg}) : div_shift[WIDTH-1:0];
  assign div_quo_next = {quo[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          case (OpCode)
            2'b10:   state_next = MUL;
            2'b11:   state_next = DIV;
            default: state_next = ADDSUB;
          endcase
        end
      end
      ADDSUB: state_next = DONE;
      MUL: if (last_iter) state_next = DONE;
      DIV: if (last_iter) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      div0_pend <= 1'b0;
      cnt       <= '0;
      prod_hi   <= '0;
      prod_lo   <= '0;
      rem       <= '0;
      quo       <= '0;
      Answer    <= '0;
      AnswerHi  <= '0;
      carry     <= 1'b0;
      div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            sub_reg   <= OpCode[0];
            div0_pend <= (OpCode == 2'b11) && (B == '0);
            cnt       <= '0;
            prod_hi   <= '0;
            prod_lo   <= A;
            rem       <= '0;
            quo       <= A;
          end
        end
        ADDSUB: begin
          Answer   <= sub_reg ? sub_diff[WIDTH-1:0] : add_sum[WIDTH-1:0];
          carry    <= sub_reg ? sub_diff[WIDTH] : add_sum[WIDTH];
          AnswerHi <= '0;
          div0     <= 1'b0;
        end
        MUL: begin
          {prod_hi, prod_lo} <= mul_next;
          if (last_iter) begin
            cnt      <= '0;
            Answer   <= mul_next[WIDTH-1:0];
            AnswerHi <= mul_next[2*WIDTH-1:WIDTH];
            carry    <= 1'b0;
            div0     <= 1'b0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        DIV: begin
          rem <= div_rem_next;
          quo <= div_quo_next;
          if (last_iter) begin
            cnt      <= '0;
            Answer   <= div_quo_next;
            AnswerHi <= div_rem_next;
            carry    <= 1'b0;
            div0     <= div0_pend;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uarith_sequencer.sv
// tb/tb_uarith_sequencer.sv - directed self-checking bench for uarith_sequencer
module tb_uarith_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       OpCode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Answer;
  logic [WIDTH-1:0] AnswerHi;
  logic             carry;
  logic             div0;

  int total = 0;
  int bad   = 0;

  uarith_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .OpCode   (OpCode),
    .A        (A),
    .B        (B),
    .ready    (ready),
    .done     (done),
    .Answer   (Answer),
    .AnswerHi (AnswerHi),
    .carry    (carry),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to done. Sampling is on the falling edge;
  // k counts rising edges after the accept edge N.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_lo, input logic [WIDTH-1:0] exp_hi,
                        input logic exp_carry, input logic exp_div0,
                        input int exp_lat, input bit inject);
    logic [WIDTH-1:0] prev_lo;
    logic [WIDTH-1:0] prev_hi;
    logic             prev_c;
    logic             prev_d;
    int               lat;
    int               rlow;
    bit               hold_ok;
    @(negedge clk);
    prev_lo = Answer;
    prev_hi = AnswerHi;
    prev_c  = carry;
    prev_d  = div0;
    OpCode  = op;
    A       = a;
    B       = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    // Scramble inputs after acceptance; they must not matter.
    A       = ~a;
    B       = ~b;
    OpCode  = ~op;
    lat     = -1;
    rlow    = 0;
    hold_ok = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      if (!ready) rlow++;
      if (done) begin
        lat = k;
        break;
      end
      if (Answer !== prev_lo || AnswerHi !== prev_hi || carry !== prev_c || div0 !== prev_d)
        hold_ok = 1'b0;
      if (inject && k == 5) begin
        start  = 1'b1;
        OpCode = 2'b00;
        A      = 1;
        B      = 1;
      end
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat + 1));
    check({tag, "_ready_low"}, 64'(rlow), 64'(exp_lat + 2));
    check({tag, "_answer"}, 64'(Answer), 64'(exp_lo));
    check({tag, "_answer_hi"}, 64'(AnswerHi), 64'(exp_hi));
    check({tag, "_carry"}, 64'(carry), 64'(exp_carry));
    check({tag, "_div0"}, 64'(div0), 64'(exp_div0));
    check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    @(negedge clk);
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_ready_after"}, 64'(ready), 64'd1);
    check({tag, "_answer_kept"}, 64'(Answer), 64'(exp_lo));
  endtask

  initial begin
    int dones;
    reset  = 1'b1;
    start  = 1'b0;
    OpCode = 2'b00;
    A      = '0;
    B      = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_answer", 64'(Answer), 64'd0);
    check("rst_answer_hi", 64'(AnswerHi), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    reset = 1'b0;

    // Latency argument is the number of edges after N at which done appears, minus 1:
    // add/sub done after N+1 -> sample k=1; mul/div after N+32 -> k=32.
    run_op("add_ovf", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_borrow", 2'b01, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_plain", 2'b01, 32'd5, 32'd3, 32'd2, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_plain", 2'b00, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    run_op("mul_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 31, 1'b0);
    run_op("mul_shift", 2'b10, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 1'b0, 1'b0, 31, 1'b0);
    run_op("div_100_7", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 31, 1'b0);
    run_op("div_by0", 2'b11, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b0, 1'b1, 31, 1'b0);
    run_op("div_small", 2'b11, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0, 31, 1'b0);
    run_op("mul_busy", 2'b10, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 1'b0, 31, 1'b1);

    // Reset in the middle of a divide: abort at iteration 10.
    @(negedge clk);
    OpCode = 2'b11;
    A      = 32'd100;
    B      = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(ready), 64'd0);
    check("mid_answer_prev", 64'(Answer), 64'd15);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_answer", 64'(Answer), 64'd0);
    check("mid_rst_answer_hi", 64'(AnswerHi), 64'd0);
    check("mid_rst_carry", 64'(carry), 64'd0);
    check("mid_rst_div0", 64'(div0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", 64'(dones), 64'd0);
    check("mid_rst_idle", 64'(ready), 64'd1);

    run_op("add_after_rst", 2'b00, 32'd2, 32'd2, 32'd4, 32'd0, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
